// File: rtl/pdp11_fetch_unit.sv
// PDP-11 instruction fetch front end: walks a byte PC, reads 16-bit words from
// 1-cycle-latency flash and queues {word, pc} for decode behind a valid/ready handshake.
module pdp11_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'o000000,
    parameter int          MEM_WORDS = 1024,
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       o_mem_req,
    output logic [ADDR_W-1:0]          o_mem_addr,
    input  logic [15:0]                i_mem_rdata,
    output logic                       o_instr_valid,
    input  logic                       i_instr_ready,
    output logic [15:0]                o_instr_word,
    output logic [15:0]                o_instr_pc,
    input  logic                       i_redirect_valid,
    input  logic [15:0]                i_redirect_pc,
    input  logic                       i_halt,
    output logic                       o_fetch_fault,
    output logic [$clog2(DEPTH):0]     o_occupancy
);

    localparam int          PTR_W    = $clog2(DEPTH);
    localparam int          CNT_W    = PTR_W + 1;
    localparam logic [16:0] PC_LIMIT = 17'(2 * MEM_WORDS);

    logic [15:0]      r_fetch_pc;
    logic             r_inflight;
    logic [15:0]      r_inflight_pc;
    logic             r_fault;
    logic [15:0]      r_fifo_word [DEPTH];
    logic [15:0]      r_fifo_pc   [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_last_word;
    logic [15:0]      r_last_pc;

    logic             w_pc_in_range;
    logic             w_credit;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_valid;
    logic [15:0]      w_head_word;
    logic [15:0]      w_head_pc;

    // Issue/credit decision and FIFO handshake terms; the credit check counts the
    // in-flight read and deliberately ignores a same-cycle pop.
    always_comb begin
        w_pc_in_range = ({1'b0, r_fetch_pc} < PC_LIMIT);
        w_credit      = ((r_count + {{PTR_W{1'b0}}, r_inflight}) < CNT_W'(DEPTH));
        w_issue       = rst_n && !i_halt && !r_fault && !i_redirect_valid
                        && w_credit && w_pc_in_range;
        w_push        = r_inflight && !i_redirect_valid;
        w_valid       = (r_count != {CNT_W{1'b0}});
        w_pop         = w_valid && i_instr_ready;
        w_head_word   = r_fifo_word[r_rd_ptr];
        w_head_pc     = r_fifo_pc[r_rd_ptr];
    end

    // Output mapping; an empty queue keeps showing the last presented head.
    always_comb begin
        o_mem_req     = w_issue;
        o_mem_addr    = rst_n ? r_fetch_pc[ADDR_W:1] : {ADDR_W{1'b0}};
        o_instr_valid = w_valid;
        if (w_valid) begin
            o_instr_word = w_head_word;
            o_instr_pc   = w_head_pc;
        end else begin
            o_instr_word = r_last_word;
            o_instr_pc   = r_last_pc;
        end
        o_fetch_fault = r_fault;
        o_occupancy   = r_count;
    end

    // Fetch PC, in-flight tracking, prefetch queue and fault state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC & 16'hFFFE;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 16'h0000;
            r_fault       <= 1'b0;
            r_wr_ptr      <= {PTR_W{1'b0}};
            r_rd_ptr      <= {PTR_W{1'b0}};
            r_count       <= {CNT_W{1'b0}};
            r_last_word   <= 16'h0000;
            r_last_pc     <= 16'h0000;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_word[i] <= 16'h0000;
                r_fifo_pc[i]   <= 16'h0000;
            end
        end else begin
            if (w_valid) begin
                r_last_word <= w_head_word;
                r_last_pc   <= w_head_pc;
            end
            if (i_redirect_valid) begin
                // Flush wins over everything, including the response landing this cycle.
                r_fetch_pc <= i_redirect_pc & 16'hFFFE;
                r_fault    <= i_redirect_pc[0];
                r_inflight <= 1'b0;
                r_wr_ptr   <= {PTR_W{1'b0}};
                r_rd_ptr   <= {PTR_W{1'b0}};
                r_count    <= {CNT_W{1'b0}};
            end else begin
                if (w_push) begin
                    r_fifo_word[r_wr_ptr] <= i_mem_rdata;
                    r_fifo_pc[r_wr_ptr]   <= r_inflight_pc;
                    r_wr_ptr              <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
                end
                r_count    <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_inflight_pc <= r_fetch_pc;
                    r_fetch_pc    <= r_fetch_pc + 16'h0002;
                end
                if (!w_pc_in_range) begin
                    r_fault <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdp11_fetch_unit.sv
// Directed self-checking bench for pdp11_fetch_unit with a 64-word flash model
// holding flash[i] = i + 1, so every word identifies its own byte PC.
module tb_pdp11_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [5:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_word;
    logic [15:0] instr_pc;
    logic        redir_valid;
    logic [15:0] redir_pc;
    logic        halt;
    logic        fetch_fault;
    logic [2:0]  occupancy;

    logic [15:0] flash [64];
    int          n_checks;
    int          n_errors;
    int          exp_w;
    int          exp_pc;
    int          reqs;

    pdp11_fetch_unit #(
        .RESET_PC (16'o000000),
        .MEM_WORDS(64),
        .DEPTH    (4),
        .ADDR_W   (6)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .o_mem_req       (mem_req),
        .o_mem_addr      (mem_addr),
        .i_mem_rdata     (mem_rdata),
        .o_instr_valid   (instr_valid),
        .i_instr_ready   (instr_ready),
        .o_instr_word    (instr_word),
        .o_instr_pc      (instr_pc),
        .i_redirect_valid(redir_valid),
        .i_redirect_pc   (redir_pc),
        .i_halt          (halt),
        .o_fetch_fault   (fetch_fault),
        .o_occupancy     (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flash with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= flash[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then drive the inputs for the new cycle and let outputs settle.
    task automatic cyc(input logic r, input logic h, input logic rv, input logic [15:0] rp);
        @(posedge clk);
        #1;
        instr_ready = r;
        halt        = h;
        redir_valid = rv;
        redir_pc    = rp;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 64; i++) flash[i] = 16'(i + 1);
        mem_rdata   = 16'h0000;
        rst_n       = 1'b0;
        instr_ready = 1'b1;
        halt        = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 16'h0000;

        #12;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_word", instr_word, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_fault", fetch_fault, 0);
        check("rst_occ", occupancy, 0);

        // Cycle 0: first request as soon as reset is released.
        @(posedge clk); #1; rst_n = 1'b1; #1;
        check("c0_req", mem_req, 1);
        check("c0_addr", mem_addr, 0);
        check("c0_valid", instr_valid, 0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("c1_addr", mem_addr, 1);
        check("c1_valid", instr_valid, 0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("c2_valid", instr_valid, 1);
        check("c2_word", instr_word, 1);
        check("c2_pc", instr_pc, 0);
        check("c2_addr", mem_addr, 2);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("c3_word", instr_word, 2);
        check("c3_pc", instr_pc, 2);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("c4_word", instr_word, 3);
        check("c4_pc", instr_pc, 4);
        check("c4_occ", occupancy, 1);
        instr_ready = 1'b0;

        // Backpressure: queue fills, requests stop, head stays put.
        for (int i = 0; i < 9; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0000);
            check("stall_head_word", instr_word, 3);
            check("stall_head_pc", instr_pc, 4);
        end
        check("full_occ", occupancy, 4);
        check("full_req", mem_req, 0);
        check("full_valid", instr_valid, 1);

        exp_w = 3;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0000);
            check("drain_valid", instr_valid, 1);
            check("drain_word", instr_word, 32'(exp_w));
            check("drain_pc", instr_pc, 32'(2 * (exp_w - 1)));
            exp_w++;
        end

        // Redirect with 3 queued and 1 in flight.
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        check("pre_redir_occ", occupancy, 2);
        check("pre_redir_word", instr_word, 11);
        cyc(1'b0, 1'b0, 1'b1, 16'o100);
        check("redir_occ", occupancy, 3);
        check("redir_no_req", mem_req, 0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("redir1_valid", instr_valid, 0);
        check("redir1_occ", occupancy, 0);
        check("redir1_req", mem_req, 1);
        check("redir1_addr", mem_addr, 32);
        check("redir1_hold_word", instr_word, 11);
        check("redir1_hold_pc", instr_pc, 20);
        reqs = 1;
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("redir2_valid", instr_valid, 0);
        check("redir2_addr", mem_addr, 33);
        reqs += int'(mem_req);

        // Run to the end of flash: last valid pc 126, then fault.
        exp_pc = 64;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0000);
            if (i == 0) check("redir3_valid", instr_valid, 1);
            if (mem_req) reqs++;
            if (instr_valid) begin
                check("run_pc", instr_pc, 32'(exp_pc));
                check("run_word", instr_word, 32'(exp_pc / 2 + 1));
                exp_pc += 2;
            end
        end
        check("end_next_pc", 32'(exp_pc), 128);
        check("end_req_count", 32'(reqs), 32);
        check("end_fault", fetch_fault, 1);
        check("end_req", mem_req, 0);
        check("end_valid", instr_valid, 0);

        // Redirect to 0 clears the fault and restarts fetch.
        cyc(1'b1, 1'b0, 1'b1, 16'h0000);
        check("clr_req", mem_req, 0);
        check("clr_fault_still", fetch_fault, 1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("clr_fault", fetch_fault, 0);
        check("clr_req1", mem_req, 1);
        check("clr_addr1", mem_addr, 0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("clr_addr2", mem_addr, 1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("clr_valid", instr_valid, 1);
        check("clr_word", instr_word, 1);
        check("clr_pc", instr_pc, 0);

        // Odd redirect target faults and blocks issue.
        cyc(1'b1, 1'b0, 1'b1, 16'o101);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("odd_fault", fetch_fault, 1);
        check("odd_req", mem_req, 0);
        check("odd_valid", instr_valid, 0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("odd_req2", mem_req, 0);
        check("odd_valid2", instr_valid, 0);

        // Halt pulse of 3 cycles: no requests, PC sequence continues afterwards.
        cyc(1'b1, 1'b0, 1'b1, 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("h1_fault", fetch_fault, 0);
        check("h1_addr", mem_addr, 0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("h2_addr", mem_addr, 1);
        exp_pc = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, (i < 3), 1'b0, 16'h0000);
            if (i < 3) check("halt_no_req", mem_req, 0);
            if (i == 3) begin
                check("halt_resume_req", mem_req, 1);
                check("halt_resume_addr", mem_addr, 2);
            end
            if (instr_valid) begin
                check("halt_pc", instr_pc, 32'(exp_pc));
                check("halt_word", instr_word, 32'(exp_pc / 2 + 1));
                exp_pc += 2;
            end
        end
        check("halt_seq_end", 32'(exp_pc), 18);

        // Reset in the middle of a busy queue with a read in flight.
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        check("busy_occ", occupancy, 3);
        check("busy_req", mem_req, 0);
        #2; rst_n = 1'b0; #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_valid", instr_valid, 0);
        check("mid_rst_word", instr_word, 0);
        check("mid_rst_pc", instr_pc, 0);
        check("mid_rst_fault", fetch_fault, 0);
        check("mid_rst_occ", occupancy, 0);
        @(posedge clk); #1; instr_ready = 1'b1; #1;
        check("hold_rst_occ", occupancy, 0);
        check("hold_rst_req", mem_req, 0);
        rst_n = 1'b1; #1;
        check("restart_req", mem_req, 1);
        check("restart_addr", mem_addr, 0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("restart_addr1", mem_addr, 1);
        check("restart_valid1", instr_valid, 0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("restart_word", instr_word, 1);
        check("restart_pc", instr_pc, 0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        check("restart_word2", instr_word, 2);
        check("restart_pc2", instr_pc, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
